// File: rtl/vga_pattern_gen_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen_if
// Purpose  : Pattern-select inputs and video outputs of the VGA test-pattern
//            generator, bundled for the picoPPU display path.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 4
);
  logic [1:0]           mode_i;
  logic [3*COLOR_W-1:0] solid_rgb_i;
  logic [COLOR_W-1:0]   vgaRed;
  logic [COLOR_W-1:0]   vgaGreen;
  logic [COLOR_W-1:0]   vgaBlue;
  logic                 Hsync;
  logic                 Vsync;
  logic                 frame_start_o;

  // Video source side: takes the pattern controls, drives colour and sync.
  modport master (
    input  mode_i, solid_rgb_i,
    output vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_start_o
  );

  // Consumer side: sets the pattern controls, receives colour and sync.
  modport slave (
    output mode_i, solid_rgb_i,
    input  vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_start_o
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Purpose  : VGA timing and test-pattern generator (solid, colour bars,
//            checkerboard, grey gradient) with registered sync and blanked RGB.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 5
) (
  input wire                clk,
  input wire                reset_n,
  vga_pattern_gen_if.master vif
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so the sync-end bound always fits.
  localparam int c_hw      = $clog2(c_h_total + 1);
  localparam int c_vw      = $clog2(c_v_total + 1);
  // A divide-by-one still gets a 1-bit counter that simply stays at zero.
  localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_bar_len = H_ACTIVE / 8;
  localparam int c_bw      = (c_bar_len > 1) ? $clog2(c_bar_len) : 1;

  localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
  localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_active = c_hw'(H_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_start = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_end   = c_hw'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_active = c_vw'(V_ACTIVE);
  localparam logic [c_vw-1:0] c_vs_start = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_end   = c_vw'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [c_bw-1:0] c_bar_last = c_bw'(c_bar_len - 1);

  // Elaboration-time parameter sanity checks.
  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("vga_pattern_gen: CLK_DIV must be >= 1");
  end
  if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8) begin : g_chk_h_active
    $error("vga_pattern_gen: H_ACTIVE must be a non-zero multiple of 8");
  end
  if (CHECK_LOG2 >= c_hw || CHECK_LOG2 >= c_vw) begin : g_chk_checker
    $error("vga_pattern_gen: CHECK_LOG2 exceeds counter width");
  end
  if (GRAD_SHIFT + COLOR_W > c_hw) begin : g_chk_gradient
    $error("vga_pattern_gen: GRAD_SHIFT+COLOR_W exceeds h counter width");
  end

  logic [c_dw-1:0]    r_div_cnt;
  logic [c_hw-1:0]    r_h_cnt;
  logic [c_vw-1:0]    r_v_cnt;
  logic [c_bw-1:0]    r_bar_cnt;
  logic [2:0]         r_bar_idx;
  logic [1:0]         r_mode;
  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic               r_hsync, r_vsync, r_frame_start;

  logic               w_pix_tick, w_h_wrap, w_v_wrap, w_frame_end;
  logic               w_active, w_hs_act, w_vs_act, w_chk;
  logic [COLOR_W-1:0] w_red, w_green, w_blue;

  assign w_pix_tick  = (r_div_cnt == c_div_last);
  assign w_h_wrap    = (r_h_cnt == c_h_last);
  assign w_v_wrap    = (r_v_cnt == c_v_last);
  assign w_frame_end = w_h_wrap && w_v_wrap;
  assign w_active    = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
  assign w_hs_act    = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
  assign w_vs_act    = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
  assign w_chk       = r_h_cnt[CHECK_LOG2] ^ r_v_cnt[CHECK_LOG2];

  // Pixel-rate divider: free-running count that produces one tick per pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_div_cnt <= '0;
    else if (w_pix_tick) r_div_cnt <= '0;
    else                 r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Raster position: h advances per pixel, v advances when h wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Colour-bar index tracks h_cnt / (H_ACTIVE/8) without a divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_pix_tick) begin
      if (w_h_wrap) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_cnt == c_bar_last) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 1'b1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 1'b1;
      end
    end
  end

  // Pattern select is only taken at the last pixel of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_mode <= 2'd0;
    else if (w_pix_tick && w_frame_end) r_mode <= vif.mode_i;
  end

  // Pattern colour for the current raster position, zero in blanking.
  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (w_active) begin
      case (r_mode)
        2'd0: {w_red, w_green, w_blue} = vif.solid_rgb_i;
        2'd1: begin
          // Bar order white..black maps to inverted index bits per channel.
          w_red   = {COLOR_W{~r_bar_idx[1]}};
          w_green = {COLOR_W{~r_bar_idx[2]}};
          w_blue  = {COLOR_W{~r_bar_idx[0]}};
        end
        2'd2: begin
          w_red   = {COLOR_W{~w_chk}};
          w_green = {COLOR_W{~w_chk}};
          w_blue  = {COLOR_W{~w_chk}};
        end
        default: begin
          w_red   = r_h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT];
          w_green = r_h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT];
          w_blue  = r_h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT];
        end
      endcase
    end
  end

  // Output registers load the pre-increment pixel so colour and sync align.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
      if (w_pix_tick) begin
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
        r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign vif.vgaRed        = r_red;
  assign vif.vgaGreen      = r_green;
  assign vif.vgaBlue       = r_blue;
  assign vif.Hsync         = r_hsync;
  assign vif.Vsync         = r_vsync;
  assign vif.frame_start_o = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Self-contained, parametrised VGA timing and test-pattern generator for the picoPPU display path. It derives the pixel rate from the system clock and produces registered Hsync/Vsync and blanked RGB. It offers four selectable patterns: solid colour, 8 colour bars, checkerboard and grey gradient. Pattern selection changes only at frame boundaries. The block is the bring-up and diagnostic source in front of the monitor connector, ahead of the tile/sprite renderer.

## Interface
- CLK_DIV, 4: system clocks per pixel (≥1); 100 MHz → 25 MHz pixel rate.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing, in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing, in lines.
- SYNC_POL, 0: sync asserted level (0 = active-low).
- COLOR_W, 4: bits per colour channel.
- CHECK_LOG2, 5: checker square edge = 2^CHECK_LOG2 pixels.
- GRAD_SHIFT, 5: gradient level = h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT].
- H_ACTIVE must be divisible by 8. Parameter checks reject other values at elaboration.
- Ports:
  - clk  in  1  system clock
  - reset_n  in  1  asynchronous, active-low reset
  - mode_i  in  2  pattern: 0 solid, 1 bars, 2 checker, 3 gradient
  - solid_rgb_i  in  3*COLOR_W  solid colour {R,G,B}
  - vgaRed / vgaGreen / vgaBlue  out  COLOR_W each  pixel colour, 0 in blanking
  - Hsync / Vsync  out  1  sync outputs
  - frame_start_o  out  1  one-clk pulse when pixel (0,0) is presented

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick = (div_cnt == CLK_DIV-1).
- On pix_tick, h_cnt advances 0..H_TOTAL-1 and wraps. When h_cnt wraps, v_cnt advances 0..V_TOTAL-1 and wraps.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Hsync is asserted while H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. With defaults this is 656..751.
- Vsync is asserted while V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. With defaults this is 490..491.
- mode_q loads mode_i on the pix_tick where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. A mid-frame change takes effect at the next frame. solid_rgb_i is sampled live.
- Patterns (per pixel, active region only):
  - Solid: solid_rgb_i.
  - Bars: bar_idx = h_cnt / (H_ACTIVE/8). Implement with a bar-width counter and a 3-bit index; no divider. Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or zero.
  - Checker: white if h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] = 0, else black.
  - Gradient: R = G = B = h_cnt[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT]. Wraps modulo 2^COLOR_W; with defaults it wraps at x = 512.
- Outside the active region, RGB = 0 in every mode.

## Timing
- All outputs are registered and update only on pix_tick edges. Each value holds for CLK_DIV clocks.
- On a pix_tick edge, the output registers load colour/sync computed from the pre-increment (h_cnt, v_cnt). The counters advance on the same edge. Colour and sync are therefore mutually aligned, with one pixel of latency from the counters.
- frame_start_o is high for exactly one clk, following the edge that loads pixel (0,0).
- Reset (reset_n low, asynchronous):
  - div_cnt, h_cnt, v_cnt, bar counters and mode_q = 0.
  - RGB = 0.
  - Hsync = Vsync = ~SYNC_POL (deasserted).
  - frame_start_o = 0.
- Reset asserted mid-frame aborts immediately. After release, the timing restarts at pixel (0,0).
- The first pix_tick is on the CLK_DIV-th rising edge after release. That edge loads pixel (0,0) and pulses frame_start_o.
- CLK_DIV = 1 gives pix_tick on every edge. The counter logic must not produce a zero-width div_cnt.
- Default frame period: 800 × 525 × 4 = 1,680,000 clks. Line period: 3,200 clks.

## Test plan
- Reset: hold reset_n low with mode_i=1, randomised inputs. Required: RGB=0, Hsync=Vsync=1, frame_start_o=0 throughout. Releasing reset mid-line restarts at (0,0); frame_start_o is seen on the 4th edge after release.
- Sync timing (defaults): edges counted from reset release.
  - Hsync falls at edge 4+656·4 = 2628, stays low 384 clks, period 3200.
  - Vsync is low for exactly 2 lines (6400 clks) starting at line 490.
  - frame_start_o period is 1,680,000 clks.
- Bars, mode 1, line 0:
  - x=0..79 → (F,F,F).
  - x=80 → (F,F,0).
  - x=560..639 → (0,0,0).
  - x=640..799 → 0 (blanking).
- Checker, mode 2:
  - (0,0) white.
  - (32,0) black.
  - (32,32) white.
  - (639,479) black.
  - Line 480 all zero.
- Gradient, mode 3: x=0 → 0, x=32 → 1, x=511 → F, x=512 → 0.
- Mode switch: solid_rgb_i=0xF00, mode 0. Change mode_i 0→2 at line 100.
  - The rest of the frame stays (F,0,0).
  - The next frame's pixel (0,0) is white checker.
  - With CLK_DIV=1 rebuild, the same checks hold at 1 clk per pixel.
